phold_engine: RTL and testbench
===============================

PHOLD_ENGINE -- requirements
Module: phold_engine

Interface
REQ-001 SHALL have parameter NIDB, default 3: LP ID width.
REQ-002 SHALL have parameter NRB, default 8: random input width; NRB > NIDB required.
REQ-003 SHALL have parameter NTB, default 16: timestamp width.
REQ-004 SHALL have parameter MIN_DELAY, default 10: minimum timestamp increment.
REQ-005 SHALL have parameter NDB, default 3: processing-delay field width; NDB <= NRB-NIDB.
REQ-006 SHALL have parameter ALLOW_SELF, default 1: 0 forbids self-targeted events.
REQ-007 SHALL have port clk, input, 1: clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port in_valid, input, 1: incoming event offered.
REQ-010 SHALL have port in_ready, output, 1: engine can accept an event.
REQ-011 SHALL have port in_id, input, NIDB: ID of the LP receiving the event.
REQ-012 SHALL have port in_time, input, NTB: event timestamp.
REQ-013 SHALL have port global_time, input, NTB: current GVT.
REQ-014 SHALL have port random_in, input, NRB: random word.
REQ-015 SHALL have port out_valid, output, 1: new event available.
REQ-016 SHALL have port out_ready, input, 1: consumer accepts the new event.
REQ-017 SHALL have port out_time, output, NTB: new event timestamp.
REQ-018 SHALL have port out_target, output, NIDB: destination LP.
REQ-019 SHALL have port out_src, output, NIDB: captured in_id.
REQ-020 SHALL have port evt_count, output, 16: emitted-event count.
REQ-021 SHALL have port causality_err, output, 1: sticky flag, set when in_time < global_time.

Function
REQ-022 SHALL implement FSM IDLE -> WORK -> EMIT -> IDLE, with in_ready = (state==IDLE).
REQ-023 SHALL, on accept (in_valid & in_ready at an edge), register in_id, in_time, global_time and random_in, clear counter to 0 and enter WORK.
REQ-024 SHALL define field rnd_lo = rnd[NRB-NIDB-1:0], field target = rnd[NRB-1:NRB-NIDB], and field delay = rnd[NDB-1:0].
REQ-025 SHALL, in WORK, increment counter when counter != delay, and otherwise enter EMIT; out_valid therefore rises delay+1 edges after the accepting edge.
REQ-026 SHALL compute out_time = captured time + MIN_DELAY + rnd_lo at NTB+1 bits, saturating to all-ones on overflow.
REQ-027 SHALL output out_target = target, except that when ALLOW_SELF=0 and target == captured id, out_target = (id+1) mod 2^NIDB.
REQ-028 SHALL, in EMIT, hold out_valid=1 with out_time, out_target and out_src stable until out_ready=1.
REQ-029 SHALL, on the out_valid & out_ready edge, return to IDLE, drop out_valid, and increment evt_count (wrap at 16'hFFFF -> 0).
REQ-030 SHALL NOT accept a new event in the same cycle as the emit handshake; the next accept occurs at the earliest one edge later.
REQ-031 SHALL set causality_err on an accept with in_time < global_time (unsigned) and still process that event normally.
REQ-032 SHALL ignore in_valid, in_id, in_time, global_time and random_in changes outside IDLE.

Reset
REQ-033 SHALL, while rst_n=0 (asynchronously), force state=IDLE, counter=0, out_valid=0, evt_count=0, causality_err=0, out_time=0, out_target=0 and out_src=0.
REQ-034 SHALL, after rst_n deassertion, hold in_ready=1 and accept on the first edge with in_valid=1.
REQ-035 SHALL abandon any in-flight event on reset mid-WORK or mid-EMIT, with no emission and no count.

Verification (defaults: rnd_lo=rnd[4:0], target=rnd[7:5], delay=rnd[2:0])
REQ-036 SHALL cover: in_id=2, in_time=100, gvt=90, random_in=8'hA3, out_ready=1 -> out_valid rises 4 edges after accept, out_time=113, out_target=5, out_src=2, evt_count=1.
REQ-037 SHALL cover: in_time=16'hFFF0, random_in=8'h1F -> out_time=16'hFFFF (saturated), out_target=0, out_valid rises 8 edges after accept.
REQ-038 SHALL cover: ALLOW_SELF=0, in_id=5, random_in=8'hA0 -> out_target=6; and in_id=7, random_in=8'hE0 -> out_target=0.
REQ-039 SHALL cover: out_ready held 0 for 5 cycles in EMIT -> out_valid and outputs stable, in_ready=0, in_valid pulses ignored, evt_count increments exactly once on release.
REQ-040 SHALL cover: in_time=50, global_time=60 -> causality_err=1 and stays 1 through later good events, and the event is still emitted with out_time=60+rnd_lo.
REQ-041 SHALL cover: rst_n pulsed low mid-WORK -> out_valid=0, evt_count=0, causality_err=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/phold_engine.sv
// ---------------------------------------------------------------------------
// phold_engine
//   One PHOLD event-processing engine. It accepts an incoming event, waits a
//   pseudo-random processing delay and then emits one new event. The new
//   event's timestamp and destination LP are derived from the random word
//   that was captured when the incoming event was accepted.
//
// Parameters
//   NIDB       LP ID width
//   NRB        random word width (must be greater than NIDB)
//   NTB        timestamp width
//   MIN_DELAY  minimum timestamp increment
//   NDB        processing-delay field width (at most NRB-NIDB)
//   ALLOW_SELF 0 redirects an event that would target its own LP
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       incoming event offered
//   in_ready       engine is idle and can accept an event
//   in_id          ID of the LP receiving the incoming event
//   in_time        incoming event timestamp
//   global_time    current GVT
//   random_in      random word used to generate the new event
//   out_valid      new event available
//   out_ready      consumer accepts the new event
//   out_time       new event timestamp (saturating)
//   out_target     destination LP of the new event
//   out_src        LP that generated the new event
//   evt_count      number of emitted events (wraps)
//   causality_err  sticky: an event older than GVT was accepted
// ---------------------------------------------------------------------------
module phold_engine #(
    parameter int NIDB       = 3,
    parameter int NRB        = 8,
    parameter int NTB        = 16,
    parameter int MIN_DELAY  = 10,
    parameter int NDB        = 3,
    parameter int ALLOW_SELF = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NIDB-1:0] in_id,
    input  logic [NTB-1:0]  in_time,
    input  logic [NTB-1:0]  global_time,
    input  logic [NRB-1:0]  random_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NTB-1:0]  out_time,
    output logic [NIDB-1:0] out_target,
    output logic [NIDB-1:0] out_src,
    output logic [15:0]     evt_count,
    output logic            causality_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WORK,
        S_EMIT
    } state_t;

    state_t          r_state;
    logic [NIDB-1:0] r_id;
    logic [NTB-1:0]  r_time;
    logic [NTB-1:0]  r_gvt;
    logic [NRB-1:0]  r_rnd;
    logic [NDB-1:0]  r_cnt;

    logic [NRB-NIDB-1:0] w_rnd_lo;
    logic [NIDB-1:0]     w_target;
    logic [NDB-1:0]      w_delay;
    logic [NTB:0]        w_sum;
    logic [NTB-1:0]      w_time_sat;
    logic [NIDB-1:0]     w_dest;

    assign w_rnd_lo = r_rnd[NRB-NIDB-1:0];
    assign w_target = r_rnd[NRB-1:NRB-NIDB];
    assign w_delay  = r_rnd[NDB-1:0];

    // One extra bit catches overflow so the timestamp can saturate.
    assign w_sum      = {1'b0, r_time} + (NTB+1)'(MIN_DELAY) + (NTB+1)'(w_rnd_lo);
    assign w_time_sat = w_sum[NTB] ? '1 : w_sum[NTB-1:0];

    // Self-targeted events move on to the next LP, wrapping at the top ID.
    assign w_dest = (ALLOW_SELF == 0 && w_target == r_id) ? r_id + NIDB'(1) : w_target;

    assign in_ready = (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_id          <= '0;
            r_time        <= '0;
            r_gvt         <= '0;
            r_rnd         <= '0;
            r_cnt         <= '0;
            out_valid     <= 1'b0;
            out_time      <= '0;
            out_target    <= '0;
            out_src       <= '0;
            evt_count     <= '0;
            causality_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_id    <= in_id;
                        r_time  <= in_time;
                        r_gvt   <= global_time;
                        r_rnd   <= random_in;
                        r_cnt   <= '0;
                        r_state <= S_WORK;
                    end
                end
                S_WORK: begin
                    // The counter is zero only on the first WORK cycle, so the
                    // causality check runs exactly once per accepted event.
                    if (r_cnt == '0 && r_time < r_gvt) begin
                        causality_err <= 1'b1;
                    end
                    if (r_cnt != w_delay) begin
                        r_cnt <= r_cnt + NDB'(1);
                    end else begin
                        r_state    <= S_EMIT;
                        out_valid  <= 1'b1;
                        out_time   <= w_time_sat;
                        out_target <= w_dest;
                        out_src    <= r_id;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                        evt_count <= evt_count + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phold_engine.sv
// ---------------------------------------------------------------------------
// tb_phold_engine
//   Two engines share all inputs: one with self-targeting allowed and one
//   with it forbidden. Directed table vectors, hand-written reset sequences
//   and random events are checked against expected values computed here.
// ---------------------------------------------------------------------------
module tb_phold_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_id = '0;
    logic [15:0] in_time = '0;
    logic [15:0] global_time = '0;
    logic [7:0]  random_in = '0;
    logic        out_ready = 1'b0;

    logic        rdy_a, ov_a, ce_a;
    logic [15:0] ot_a, cnt_a;
    logic [2:0]  tg_a, src_a;
    logic        rdy_b, ov_b, ce_b;
    logic [15:0] ot_b, cnt_b;
    logic [2:0]  tg_b, src_b;

    int n_vec = 0;
    int n_err = 0;
    int m_cnt = 0;
    bit m_caus = 1'b0;

    always #5 clk = ~clk;

    phold_engine #(.NIDB(3), .NRB(8), .NTB(16), .MIN_DELAY(10), .NDB(3), .ALLOW_SELF(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .in_id(in_id), .in_time(in_time), .global_time(global_time), .random_in(random_in),
        .out_valid(ov_a), .out_ready(out_ready), .out_time(ot_a), .out_target(tg_a),
        .out_src(src_a), .evt_count(cnt_a), .causality_err(ce_a)
    );

    phold_engine #(.NIDB(3), .NRB(8), .NTB(16), .MIN_DELAY(10), .NDB(3), .ALLOW_SELF(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .in_id(in_id), .in_time(in_time), .global_time(global_time), .random_in(random_in),
        .out_valid(ov_b), .out_ready(out_ready), .out_time(ot_b), .out_target(tg_b),
        .out_src(src_b), .evt_count(cnt_b), .causality_err(ce_b)
    );

    typedef struct {
        logic [2:0]  id;
        logic [15:0] t;
        logic [15:0] g;
        logic [7:0]  rnd;
        logic [15:0] et;
        logic [2:0]  etg;
        logic [2:0]  etg_ns;
        int          lat;
        int          hold;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: new timestamp = time + 10 + (rnd mod 32) capped at
    // 65535, destination = rnd / 32, latency = (rnd mod 8) + 1 edges.
    function automatic void model(input logic [2:0] id, input logic [15:0] t, input logic [7:0] rnd,
                                  output logic [15:0] et, output logic [2:0] tg,
                                  output logic [2:0] tg_ns, output int lat);
        int s;
        int dest;
        s    = int'(t) + 10 + (int'(rnd) % 32);
        et   = (s > 65535) ? 16'hFFFF : 16'(s);
        dest = int'(rnd) / 32;
        tg   = 3'(dest);
        tg_ns = (dest == int'(id)) ? 3'((int'(id) + 1) % 8) : 3'(dest);
        lat  = (int'(rnd) % 8) + 1;
    endfunction

    task automatic run_evt(input logic [2:0] id, input logic [15:0] t, input logic [15:0] g,
                           input logic [7:0] rnd, input logic [15:0] et, input logic [2:0] etg,
                           input logic [2:0] etg_ns, input int lat, input int hold);
        int  n;
        bit  seen;
        @(negedge clk);
        chk("in_ready_idle_a", {31'b0, rdy_a}, 32'd1);
        chk("in_ready_idle_b", {31'b0, rdy_b}, 32'd1);
        in_valid = 1'b1; in_id = id; in_time = t; global_time = g; random_in = rnd;
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the engine must ignore them.
        in_valid = 1'b0; in_id = ~id; in_time = 16'($urandom); global_time = 16'hFFFF;
        random_in = 8'($urandom);
        if (t < g) m_caus = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (ov_a) seen = 1'b1;
        end
        chk("latency", n, lat);
        if (!seen) return;
        chk("out_valid_b", {31'b0, ov_b}, 32'd1);
        chk("out_time_a", {16'b0, ot_a}, {16'b0, et});
        chk("out_time_b", {16'b0, ot_b}, {16'b0, et});
        chk("out_target_a", {29'b0, tg_a}, {29'b0, etg});
        chk("out_target_b", {29'b0, tg_b}, {29'b0, etg_ns});
        chk("out_src_a", {29'b0, src_a}, {29'b0, id});
        chk("out_src_b", {29'b0, src_b}, {29'b0, id});
        chk("in_ready_busy", {31'b0, rdy_a}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'b1; in_id = 3'($urandom); in_time = 16'($urandom); random_in = 8'($urandom);
            @(posedge clk);
            #1;
            chk("hold_valid", {31'b0, ov_a}, 32'd1);
            chk("hold_time", {16'b0, ot_a}, {16'b0, et});
            chk("hold_target", {29'b0, tg_b}, {29'b0, etg_ns});
            chk("hold_src", {29'b0, src_a}, {29'b0, id});
            chk("hold_in_ready", {31'b0, rdy_a}, 32'd0);
            chk("hold_count", {16'b0, cnt_a}, 32'(m_cnt));
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = (hold > 0);  // an offer on the handshake edge must not be taken
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        m_cnt = (m_cnt + 1) % 65536;
        chk("drop_valid", {31'b0, ov_a}, 32'd0);
        chk("evt_count_a", {16'b0, cnt_a}, 32'(m_cnt));
        chk("evt_count_b", {16'b0, cnt_b}, 32'(m_cnt));
        chk("in_ready_after", {31'b0, rdy_a}, 32'd1);
        chk("causality_a", {31'b0, ce_a}, {31'b0, m_caus});
        chk("causality_b", {31'b0, ce_b}, {31'b0, m_caus});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] et;
        logic [2:0]  tg, tgns;
        int          lat;
        logic [2:0]  rid;
        logic [15:0] rt, rg;
        logic [7:0]  rr;

        //          id    time       gvt      rnd    out_time   tgt   tgt_ns lat hold
        tbl[0] = '{3'd2, 16'd100,   16'd90,  8'hA3, 16'd113,   3'd5, 3'd5, 4, 0};
        tbl[1] = '{3'd0, 16'hFFF0,  16'd0,   8'h1F, 16'hFFFF,  3'd0, 3'd1, 8, 0};
        tbl[2] = '{3'd5, 16'd200,   16'd0,   8'hA0, 16'd210,   3'd5, 3'd6, 1, 0};
        tbl[3] = '{3'd7, 16'd300,   16'd0,   8'hE0, 16'd310,   3'd7, 3'd0, 1, 0};
        tbl[4] = '{3'd1, 16'd50,    16'd60,  8'h45, 16'd65,    3'd2, 3'd2, 6, 0};
        tbl[5] = '{3'd3, 16'd1000,  16'd0,   8'h00, 16'd1010,  3'd0, 3'd0, 1, 5};
        tbl[6] = '{3'd6, 16'hFFE0,  16'd0,   8'hFF, 16'hFFFF,  3'd7, 3'd7, 8, 0};
        tbl[7] = '{3'd4, 16'hFFD6,  16'd0,   8'h1F, 16'hFFFF,  3'd0, 3'd0, 8, 2};

        // Values while reset is held.
        #12;
        chk("rst_out_valid", {31'b0, ov_a}, 32'd0);
        chk("rst_evt_count", {16'b0, cnt_a}, 32'd0);
        chk("rst_causality", {31'b0, ce_a}, 32'd0);
        chk("rst_out_time", {16'b0, ot_a}, 32'd0);
        chk("rst_out_target", {29'b0, tg_b}, 32'd0);
        chk("rst_out_src", {29'b0, src_a}, 32'd0);
        chk("rst_in_ready", {31'b0, rdy_a}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_evt(tbl[i].id, tbl[i].t, tbl[i].g, tbl[i].rnd, tbl[i].et,
                    tbl[i].etg, tbl[i].etg_ns, tbl[i].lat, tbl[i].hold);
        end

        // Reset in the middle of WORK: the in-flight event is dropped.
        @(negedge clk);
        in_valid = 1'b1; in_id = 3'd2; in_time = 16'd5; global_time = 16'd9; random_in = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_causality", {31'b0, ce_a}, 32'd1);
        chk("pre_rst_busy", {31'b0, rdy_a}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, ov_a}, 32'd0);
        chk("midrst_evt_count", {16'b0, cnt_a}, 32'd0);
        chk("midrst_causality", {31'b0, ce_a}, 32'd0);
        chk("midrst_in_ready", {31'b0, rdy_b}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0;
        m_caus = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_no_emit", {31'b0, ov_a}, 32'd0);
        chk("post_rst_count", {16'b0, cnt_b}, 32'd0);
        chk("post_rst_ready", {31'b0, rdy_a}, 32'd1);

        // Randomized events against the reference model.
        for (int i = 0; i < 40; i++) begin
            rid = 3'($urandom);
            rt  = 16'($urandom);
            rg  = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'd0;
            rr  = 8'($urandom);
            model(rid, rt, rr, et, tg, tgns, lat);
            run_evt(rid, rt, rg, rr, et, tg, tgns, lat, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
